// File: rtl/la_channel_packer.sv
// la_channel_packer: routes selected source bits into channels, samples them at a divided rate after a trigger, packs samples into words
module la_channel_packer #(
   parameter int NUM_CH = 8,
   parameter int SRC_W  = 13,
   parameter int SEL_W  = 8,
   parameter int OUT_W  = 32,
   parameter int DIV_W  = 16
) (
   input  logic                    clk_pll,
   input  logic                    reset,
   input  logic [SRC_W-1:0]        src_in,
   input  logic [NUM_CH*SEL_W-1:0] cfg_sel,
   input  logic [DIV_W-1:0]        cfg_div,
   input  logic [1:0]              cfg_trig_mode,
   input  logic [SEL_W-1:0]        cfg_trig_ch,
   input  logic [31:0]             cfg_word_count,
   input  logic                    arm,
   input  logic                    abort,
   output logic [OUT_W-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [31:0]             words_sent
);
   localparam int SPW   = OUT_W / NUM_CH;
   localparam int PC_W  = SPW > 1 ? $clog2(SPW) : 1;
   localparam int PAD_W = 2 ** SEL_W;
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;
   state_t                  state;
   logic [NUM_CH*SEL_W-1:0] sel_r;
   logic [DIV_W-1:0]        div_r, div_cnt;
   logic [1:0]              mode_r;
   logic [SEL_W-1:0]        trig_ch_r;
   logic [31:0]             count_r, produced;
   logic [PC_W-1:0]         pack_cnt;
   logic [OUT_W-1:0]        word, shifted;
   logic                    first, prev;
   logic [PAD_W-1:0]        src_pad, ch_pad;
   logic [NUM_CH-1:0]       ch, sample;
   logic                    tick, cur, fire, pack_full, take, hs;
   assign busy = state != IDLE;
   // channel routing (out-of-range selectors land in the zero padding), trigger detection and packing datapath
   always_comb begin
      src_pad = {{(PAD_W - SRC_W){1'b0}}, src_in};
      ch = '0;
      sample = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         ch[k] = src_pad[sel_r[k*SEL_W +: SEL_W]];
         sample[NUM_CH-1-k] = ch[k];
      end
      ch_pad = {{(PAD_W - NUM_CH){1'b0}}, ch};
      cur = ch_pad[trig_ch_r];
      tick = div_cnt == '0;
      fire = (mode_r == 2'd0) | ((mode_r == 2'd3) & cur) | (~first & (mode_r == 2'd1) & ~prev & cur) | (~first & (mode_r == 2'd2) & prev & ~cur);
      shifted = {sample, word[OUT_W-1:NUM_CH]};
      pack_full = pack_cnt == PC_W'(SPW - 1);
      take = tick & ((state == CAPTURE) | ((state == ARMED) & fire));
      hs = out_valid & out_ready;
   end
   // capture FSM with divider, trigger history, packer and single-slot output register
   always_ff @(posedge clk_pll or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sel_r      <= '0;
         div_r      <= '0;
         mode_r     <= '0;
         trig_ch_r  <= '0;
         count_r    <= '0;
         div_cnt    <= '0;
         pack_cnt   <= '0;
         word       <= '0;
         produced   <= '0;
         first      <= 1'b0;
         prev       <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         words_sent <= '0;
      end else begin
         done <= 1'b0;
         if (hs) begin
            out_valid  <= 1'b0;
            words_sent <= words_sent + 32'd1;
         end
         if (abort && state != IDLE) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            pack_cnt  <= '0;
         end else begin
            case (state)
               IDLE: if (arm) begin
                  sel_r      <= cfg_sel;
                  div_r      <= cfg_div;
                  mode_r     <= cfg_trig_mode;
                  trig_ch_r  <= cfg_trig_ch;
                  count_r    <= cfg_word_count;
                  overflow   <= 1'b0;
                  words_sent <= '0;
                  div_cnt    <= '0;
                  pack_cnt   <= '0;
                  produced   <= '0;
                  first      <= 1'b1;
                  state      <= cfg_word_count == 32'd0 ? DRAIN : ARMED;
               end
               ARMED, CAPTURE: begin
                  div_cnt <= tick ? div_r : div_cnt - DIV_W'(1);
                  if (tick && state == ARMED) begin
                     prev  <= cur;
                     first <= 1'b0;
                     if (fire) state <= CAPTURE;
                  end
                  if (take) begin
                     word     <= shifted;
                     pack_cnt <= pack_full ? '0 : pack_cnt + PC_W'(1);
                  end
                  if (take && pack_full) begin
                     produced <= produced + 32'd1;
                     if (!out_valid || out_ready) begin
                        out_data  <= shifted;
                        out_valid <= 1'b1;
                     end else begin
                        overflow <= 1'b1;
                     end
                     if (produced + 32'd1 == count_r) state <= DRAIN;
                  end
               end
               DRAIN: if (!out_valid || out_ready) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_la_channel_packer.sv
// tb_la_channel_packer: scoreboard bench with a tick/trigger/word reference model for la_channel_packer
module tb_la_channel_packer;
   localparam int SPW = 4;
   localparam int SEQ_L = 200;
   localparam logic [63:0] ID_SEL = 64'h0706050403020100;
   typedef struct { logic [31:0] w; int c; } exp_t;
   logic        clk_pll = 1'b0;
   logic        reset;
   logic [12:0] src_in;
   logic [63:0] cfg_sel;
   logic [15:0] cfg_div;
   logic [1:0]  cfg_trig_mode;
   logic [7:0]  cfg_trig_ch;
   logic [31:0] cfg_word_count;
   logic        arm, abort, out_ready;
   logic [31:0] out_data, words_sent;
   logic        out_valid, busy, done, overflow;
   int          checks = 0, failures = 0, cyc = 0;
   exp_t        sb[$];
   logic [12:0] seq [SEQ_L];

   la_channel_packer dut (
      .clk_pll(clk_pll), .reset(reset), .src_in(src_in), .cfg_sel(cfg_sel), .cfg_div(cfg_div),
      .cfg_trig_mode(cfg_trig_mode), .cfg_trig_ch(cfg_trig_ch), .cfg_word_count(cfg_word_count),
      .arm(arm), .abort(abort), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .overflow(overflow), .words_sent(words_sent)
   );

   always #5 clk_pll = ~clk_pll;
   // cycle index used to timestamp expected words
   always @(posedge clk_pll) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drv();
      @(posedge clk_pll);
      #1;
   endtask

   // sample byte from the channel rules: channel 0 in the MSB, out-of-range selects read 0
   function automatic logic [7:0] smp(input logic [63:0] sel, input int j);
      logic [12:0] s;
      int sk;
      s = seq[j];
      smp = '0;
      for (int k = 0; k < 8; k++) begin
         sk = int'(sel[k*8 +: 8]);
         if (sk < 13) smp[7-k] = s[sk];
      end
   endfunction

   task automatic fill(input int kind, input logic [12:0] cval);
      for (int j = 0; j < SEQ_L; j++)
         seq[j] = kind == 0 ? cval : kind == 1 ? 13'($urandom) : (j < 10 ? 13'd0 : 13'(j));
   endtask

   // monitor: every handshake pops one expected word
   always @(negedge clk_pll) begin
      exp_t e;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%h required=none", out_data);
         end else begin
            e = sb.pop_front();
            chk("word", out_data, e.w);
            if (e.c >= 0) chk("word_cycle", cyc, e.c);
         end
      end
   end

   task automatic run(input logic [63:0] sel, input int div, input int mode, input int trig, input int count, input bit rdy, input int abort_at);
      int p, m0, jl, n_exp, done_exp, dcyc, j, ab, rel_j;
      bit c, pc, fire;
      logic [7:0] v;
      logic [31:0] w, w0;
      drv();
      cfg_sel = sel;
      cfg_div = 16'(div);
      cfg_trig_mode = 2'(mode);
      cfg_trig_ch = 8'(trig);
      cfg_word_count = 32'(count);
      out_ready = rdy;
      arm = 1;
      p = cyc + 1;
      ab = abort_at;
      m0 = -1;
      pc = 0;
      for (int m = 0; m * (div + 1) < SEQ_L; m++) begin
         v = smp(sel, m * (div + 1));
         c = trig < 8 ? v[7-trig] : 1'b0;
         fire = mode == 0 ? (m == 0) : mode == 1 ? (m > 0 && !pc && c) : mode == 2 ? (m > 0 && pc && !c) : c;
         if (fire) begin
            m0 = m;
            break;
         end
         pc = c;
      end
      if (m0 >= 0 && (m0 + count * SPW - 1) * (div + 1) >= SEQ_L) m0 = -1;
      if (count > 0 && m0 < 0 && ab < 0) ab = 20;
      n_exp = 0;
      jl = 0;
      w0 = 0;
      for (int n = 0; n < count && m0 >= 0; n++) begin
         w = 0;
         for (int i = 0; i < SPW; i++) begin
            jl = (m0 + n * SPW + i) * (div + 1);
            w[i*8 +: 8] = smp(sel, jl);
         end
         if (n == 0) w0 = w;
         if (ab >= 0 && jl + 1 > ab) break;
         if (rdy || n == 0) begin
            sb.push_back('{w, rdy ? p + jl + 1 : -1});
            n_exp++;
         end
      end
      done_exp = count == 0 ? p + 1 : p + jl + 2;
      rel_j = jl + 4;
      drv();
      arm = 0;
      dcyc = -1;
      for (int t = 0; t < SEQ_L + 20; t++) begin
         j = cyc - p;
         src_in = j < SEQ_L ? seq[j] : 13'd0;
         abort = j == ab;
         if (done) begin
            dcyc = cyc;
            break;
         end
         if (!rdy && count > 0 && j == rel_j) begin
            chk("held_valid", out_valid, 1);
            chk("held_data", out_data, w0);
            chk("overflow_during_drain", overflow, count > 1);
            chk("busy_drain", busy, 1);
            out_ready = 1;
            done_exp = cyc + 1;
         end
         if (ab >= 0 && j == ab + 3) break;
         drv();
      end
      abort = 0;
      if (ab >= 0) begin
         chk("abort_no_done", dcyc != -1, 0);
         chk("abort_idle", busy, 0);
         chk("abort_valid", out_valid, 0);
      end else begin
         chk("done_cycle", dcyc, done_exp);
         chk("busy_at_done", busy, 0);
         drv();
         chk("done_pulse_len", done, 0);
      end
      chk("words_sent", words_sent, n_exp);
      chk("overflow", overflow, !rdy && count > 1 && ab < 0);
      chk("scoreboard_empty", sb.size(), 0);
      sb.delete();
      out_ready = 1;
   endtask

   initial begin
      logic [63:0] s;
      reset = 1;
      arm = 0;
      abort = 0;
      out_ready = 1;
      src_in = 0;
      cfg_sel = 0;
      cfg_div = 0;
      cfg_trig_mode = 0;
      cfg_trig_ch = 0;
      cfg_word_count = 0;
      repeat (3) drv();
      reset = 0;
      chk("reset_state", {out_data, out_valid, busy, done, overflow, words_sent}, 0);
      fill(0, 13'h0A5);
      run(ID_SEL, 0, 0, 0, 2, 1, -1);
      run(64'h1414141414141414, 0, 0, 0, 1, 1, -1);
      fill(2, 0);
      run(ID_SEL, 0, 1, 0, 2, 1, -1);
      fill(1, 0);
      run(ID_SEL, 3, 0, 0, 1, 1, -1);
      fill(1, 0);
      run(ID_SEL, 0, 0, 0, 3, 0, -1);
      fill(1, 0);
      run(ID_SEL, 0, 0, 0, 3, 1, 6);
      drv();
      cfg_sel = ID_SEL;
      cfg_div = 0;
      cfg_trig_mode = 1;
      cfg_trig_ch = 9;
      cfg_word_count = 1;
      arm = 1;
      drv();
      arm = 0;
      repeat (3) drv();
      chk("armed_busy", busy, 1);
      reset = 1;
      #1;
      chk("async_reset_outputs", {out_data, out_valid, busy, done, overflow, words_sent}, 0);
      drv();
      drv();
      reset = 0;
      run(ID_SEL, 0, 0, 0, 0, 1, -1);
      for (int r = 0; r < 20; r++) begin
         for (int k = 0; k < 8; k++) s[k*8 +: 8] = 8'($urandom_range(0, 15));
         fill(1, 0);
         run(s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(1, 3), 1, -1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
